// File: rtl/hwpe_sel_sequencer_if.sv
// Handshake and bus bundle for the HWPE selection sequencer.
//   master : request source and config-bus observer (drives *_i, reads *_o)
//   slave  : the sequencer itself
// Signals:
//   req_valid_i/req_ready_o/req_sel_i/req_en_i : selection/enable change request
//   cfg_req_i/cfg_gnt_i/cfg_r_valid_i          : config bus as seen at the HWPE
//   hwpe_busy_i                                : busy flag of the selected HWPE
//   cfg_block_o                                : masks new config requests upstream
//   hwpe_en_o/hwpe_sel_o                       : clock-gate enable and active index
//   err_o                                      : one-cycle error pulse
interface hwpe_sel_sequencer_if #(
   parameter int unsigned MAX_NUM_HWPES = 4
);
   localparam int unsigned SW = (MAX_NUM_HWPES > 1) ? $clog2(MAX_NUM_HWPES) : 1;

   logic          req_valid_i;
   logic          req_ready_o;
   logic [SW-1:0] req_sel_i;
   logic          req_en_i;
   logic          cfg_req_i;
   logic          cfg_gnt_i;
   logic          cfg_r_valid_i;
   logic          hwpe_busy_i;
   logic          cfg_block_o;
   logic          hwpe_en_o;
   logic [SW-1:0] hwpe_sel_o;
   logic          err_o;

   modport master (
      output req_valid_i, req_sel_i, req_en_i,
      output cfg_req_i, cfg_gnt_i, cfg_r_valid_i, hwpe_busy_i,
      input  req_ready_o, cfg_block_o, hwpe_en_o, hwpe_sel_o, err_o
   );

   modport slave (
      input  req_valid_i, req_sel_i, req_en_i,
      input  cfg_req_i, cfg_gnt_i, cfg_r_valid_i, hwpe_busy_i,
      output req_ready_o, cfg_block_o, hwpe_en_o, hwpe_sel_o, err_o
   );
endinterface

// File: rtl/hwpe_sel_sequencer.sv
// HWPE selection sequencer: safely changes the active HWPE index and its
// clock-gate enable. A change request first blocks new config traffic, waits
// until all granted config transactions have responded and the HWPE is idle,
// gates the clock for GUARD_CYCLES cycles, switches the selector, and finally
// applies the requested enable.
// Ports:
//   clk, rst_n : clock (rising edge), asynchronous active-low reset
//   bus        : hwpe_sel_sequencer_if.slave (request handshake, config-bus
//                observation, busy flag, block/enable/select/error outputs)
// Only req_ready_o is combinational; all other outputs are registered.
module hwpe_sel_sequencer #(
   parameter int unsigned MAX_NUM_HWPES = 4,
   parameter int unsigned N_HWPES       = 2,
   parameter int unsigned GUARD_CYCLES  = 2,
   parameter int unsigned OUTST_W       = 4
) (
   input logic                 clk,
   input logic                 rst_n,
   hwpe_sel_sequencer_if.slave bus
);

   localparam int unsigned SW = (MAX_NUM_HWPES > 1) ? $clog2(MAX_NUM_HWPES) : 1;
   // Guard counter runs 0..GUARD_CYCLES-1
   localparam int unsigned GW = (GUARD_CYCLES > 1) ? $clog2(GUARD_CYCLES) : 1;
   localparam logic [GW-1:0]      GUARD_LAST = GW'(GUARD_CYCLES - 1);
   localparam logic [OUTST_W-1:0] OUTST_MAX  = '1;

   // Elaboration-time parameter sanity
   if (N_HWPES < 1 || N_HWPES > MAX_NUM_HWPES) begin : g_bad_n_hwpes
      $error("hwpe_sel_sequencer: N_HWPES out of range");
   end
   if (GUARD_CYCLES < 1) begin : g_bad_guard
      $error("hwpe_sel_sequencer: GUARD_CYCLES must be >= 1");
   end
   if (OUTST_W < 1) begin : g_bad_outst_w
      $error("hwpe_sel_sequencer: OUTST_W must be >= 1");
   end

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      DRAIN  = 2'd1,
      GATE   = 2'd2,
      SWITCH = 2'd3
   } state_e;

   state_e             state_q, state_d;
   logic [SW-1:0]      sel_q, sel_d;
   logic               en_q, en_d;
   logic               block_q, block_d;
   logic               err_q, err_d;
   logic [OUTST_W-1:0] outst_q, outst_d;
   logic [GW-1:0]      guard_q, guard_d;
   logic [SW-1:0]      lat_sel_q, lat_sel_d;
   logic               lat_en_q, lat_en_d;

   logic cnt_inc;
   logic cnt_dec;
   logic cnt_err;
   logic sel_err;
   logic sel_invalid;
   logic req_is_noop;

   // Outstanding config-transaction counter with saturation/underflow flagging
   always_comb begin
      cnt_inc = bus.cfg_req_i & bus.cfg_gnt_i;
      cnt_dec = bus.cfg_r_valid_i;
      outst_d = outst_q;
      cnt_err = 1'b0;
      if (cnt_inc && !cnt_dec) begin
         if (outst_q == OUTST_MAX) begin
            cnt_err = 1'b1;
         end else begin
            outst_d = outst_q + OUTST_W'(1);
         end
      end else if (cnt_dec && !cnt_inc) begin
         if (outst_q == '0) begin
            cnt_err = 1'b1;
         end else begin
            outst_d = outst_q - OUTST_W'(1);
         end
      end
   end

   // Request classification
   always_comb begin
      sel_invalid = (32'(bus.req_sel_i) >= N_HWPES);
      req_is_noop = (bus.req_sel_i == sel_q) && (bus.req_en_i == en_q);
   end

   // Next-state and output logic
   always_comb begin
      state_d   = state_q;
      sel_d     = sel_q;
      en_d      = en_q;
      block_d   = block_q;
      guard_d   = guard_q;
      lat_sel_d = lat_sel_q;
      lat_en_d  = lat_en_q;
      sel_err   = 1'b0;

      unique case (state_q)
         IDLE: begin
            // In IDLE ready is high, so valid alone means acceptance
            if (bus.req_valid_i) begin
               if (sel_invalid) begin
                  sel_err = 1'b1;
               end else if (!req_is_noop) begin
                  lat_sel_d = bus.req_sel_i;
                  lat_en_d  = bus.req_en_i;
                  block_d   = 1'b1;
                  state_d   = DRAIN;
               end
            end
         end
         DRAIN: begin
            // Wait for every granted config transaction to respond and the HWPE to go idle
            if ((outst_q == '0) && !bus.hwpe_busy_i) begin
               en_d    = 1'b0;
               guard_d = '0;
               state_d = GATE;
            end
         end
         GATE: begin
            if (guard_q == GUARD_LAST) begin
               guard_d = '0;
               state_d = SWITCH;
            end else begin
               guard_d = guard_q + GW'(1);
            end
         end
         SWITCH: begin
            // Selector changes while the clock is still gated; enable follows on the same edge
            sel_d   = lat_sel_q;
            en_d    = lat_en_q;
            block_d = 1'b0;
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      err_d = sel_err | cnt_err;
   end

   // State and output registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         sel_q     <= '0;
         en_q      <= 1'b0;
         block_q   <= 1'b0;
         err_q     <= 1'b0;
         outst_q   <= '0;
         guard_q   <= '0;
         lat_sel_q <= '0;
         lat_en_q  <= 1'b0;
      end else begin
         state_q   <= state_d;
         sel_q     <= sel_d;
         en_q      <= en_d;
         block_q   <= block_d;
         err_q     <= err_d;
         outst_q   <= outst_d;
         guard_q   <= guard_d;
         lat_sel_q <= lat_sel_d;
         lat_en_q  <= lat_en_d;
      end
   end

   assign bus.req_ready_o = (state_q == IDLE);
   assign bus.cfg_block_o = block_q;
   assign bus.hwpe_en_o   = en_q;
   assign bus.hwpe_sel_o  = sel_q;
   assign bus.err_o       = err_q;

endmodule

// File: tb/tb_hwpe_sel_sequencer.sv
// Self-checking bench for hwpe_sel_sequencer: directed scenarios with literal
// expectations plus a per-cycle comparison against a countdown-based model.
module tb_hwpe_sel_sequencer;

   localparam int unsigned MAX_NUM_HWPES = 4;
   localparam int          N_HWPES       = 2;
   localparam int          GUARD_CYCLES  = 2;
   localparam int unsigned OUTST_W       = 4;
   localparam int unsigned SW            = 2;
   localparam int          OUTST_MAX     = (1 << OUTST_W) - 1;

   logic clk   = 1'b0;
   logic rst_n = 1'b1;

   always #5 clk = ~clk;

   hwpe_sel_sequencer_if #(.MAX_NUM_HWPES(MAX_NUM_HWPES)) bus ();

   hwpe_sel_sequencer #(
      .MAX_NUM_HWPES(MAX_NUM_HWPES),
      .N_HWPES      (N_HWPES),
      .GUARD_CYCLES (GUARD_CYCLES),
      .OUTST_W      (OUTST_W)
   ) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bus)
   );

   int n_checks = 0;
   int n_pass   = 0;

   task automatic chk(input string name, input int act, input int exp);
      n_checks++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
   endtask

   // ---------------- behavioural model ----------------
   // A pending change waits for drain (m_left < 0); once drained it completes
   // GUARD_CYCLES+1 edges later, and the enable drops to 0 in the meantime.
   int            m_cnt   = 0;
   bit            m_pend  = 1'b0;
   int            m_left  = -1;
   logic [SW-1:0] m_sel   = '0;
   logic [SW-1:0] p_sel   = '0;
   bit            m_en    = 1'b0;
   bit            p_en    = 1'b0;
   bit            m_block = 1'b0;
   bit            m_err   = 1'b0;
   bit            m_inc;
   bit            m_dec;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_cnt = 0; m_pend = 1'b0; m_left = -1;
         m_sel = '0; p_sel = '0; m_en = 1'b0; p_en = 1'b0;
         m_block = 1'b0; m_err = 1'b0;
      end else begin
         m_err = 1'b0;
         if (!m_pend) begin
            if (bus.req_valid_i) begin
               if (int'(bus.req_sel_i) >= N_HWPES) begin
                  m_err = 1'b1;
               end else if (bus.req_sel_i != m_sel || bus.req_en_i != m_en) begin
                  m_pend = 1'b1; m_left = -1; m_block = 1'b1;
                  p_sel = bus.req_sel_i; p_en = bus.req_en_i;
               end
            end
         end else if (m_left < 0) begin
            if (m_cnt == 0 && !bus.hwpe_busy_i) begin
               m_en = 1'b0;
               m_left = GUARD_CYCLES + 1;
            end
         end else begin
            m_left--;
            if (m_left == 0) begin
               m_sel = p_sel; m_en = p_en; m_block = 1'b0; m_pend = 1'b0;
            end
         end
         m_inc = bus.cfg_req_i & bus.cfg_gnt_i;
         m_dec = bus.cfg_r_valid_i;
         if (m_inc && !m_dec) begin
            if (m_cnt == OUTST_MAX) m_err = 1'b1;
            else m_cnt++;
         end else if (m_dec && !m_inc) begin
            if (m_cnt == 0) m_err = 1'b1;
            else m_cnt--;
         end
      end
   end

   // Per-cycle comparison against the model
   always @(negedge clk) begin
      chk("m_ready", int'(bus.req_ready_o), int'(!m_pend));
      chk("m_en",    int'(bus.hwpe_en_o),   int'(m_en));
      chk("m_sel",   int'(bus.hwpe_sel_o),  int'(m_sel));
      chk("m_block", int'(bus.cfg_block_o), int'(m_block));
      chk("m_err",   int'(bus.err_o),       int'(m_err));
   end

   // ---------------- stimulus helpers ----------------
   task automatic request(input int sel, input bit en);
      bus.req_valid_i = 1'b1;
      bus.req_sel_i   = SW'(sel);
      bus.req_en_i    = en;
      @(negedge clk);
      bus.req_valid_i = 1'b0;
   endtask

   task automatic wait_ready(input int budget);
      int n = 0;
      while (bus.req_ready_o !== 1'b1 && n < budget) begin
         @(negedge clk);
         n++;
      end
      chk("wait_ready", int'(bus.req_ready_o), 1);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, %0d/%0d so far", n_pass, n_checks);
      $fatal(1);
   end

   initial begin
      bus.req_valid_i   = 1'b0;
      bus.req_sel_i     = '0;
      bus.req_en_i      = 1'b0;
      bus.cfg_req_i     = 1'b0;
      bus.cfg_gnt_i     = 1'b0;
      bus.cfg_r_valid_i = 1'b0;
      bus.hwpe_busy_i   = 1'b0;
      #1 rst_n = 1'b0;

      // Reset values, ready high during reset
      @(negedge clk);
      chk("rst_ready", int'(bus.req_ready_o), 1);
      chk("rst_en",    int'(bus.hwpe_en_o),   0);
      chk("rst_sel",   int'(bus.hwpe_sel_o),  0);
      chk("rst_block", int'(bus.cfg_block_o), 0);
      chk("rst_err",   int'(bus.err_o),       0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      // A: sel=1 en=1 on an idle bus, new outputs 5 cycles after acceptance
      request(1, 1);
      chk("A_block_c1", int'(bus.cfg_block_o), 1);
      chk("A_ready_c1", int'(bus.req_ready_o), 0);
      @(negedge clk);
      @(negedge clk);
      @(negedge clk);
      chk("A_sel_c4",   int'(bus.hwpe_sel_o),  0);
      chk("A_en_c4",    int'(bus.hwpe_en_o),   0);
      chk("A_block_c4", int'(bus.cfg_block_o), 1);
      @(negedge clk);
      chk("A_sel_c5",   int'(bus.hwpe_sel_o),  1);
      chk("A_en_c5",    int'(bus.hwpe_en_o),   1);
      chk("A_block_c5", int'(bus.cfg_block_o), 0);
      chk("A_ready_c5", int'(bus.req_ready_o), 1);

      // B: 3 grants outstanding plus one in the acceptance cycle, then sel=0
      bus.cfg_req_i = 1'b1;
      bus.cfg_gnt_i = 1'b1;
      repeat (3) @(negedge clk);
      request(0, 1);
      bus.cfg_req_i = 1'b0;
      bus.cfg_gnt_i = 1'b0;
      repeat (5) @(negedge clk);
      chk("B_ready_drain", int'(bus.req_ready_o), 0);
      chk("B_en_drain",    int'(bus.hwpe_en_o),   1);
      for (int i = 0; i < 3; i++) begin
         bus.cfg_r_valid_i = 1'b1;
         @(negedge clk);
         bus.cfg_r_valid_i = 1'b0;
         @(negedge clk);
      end
      chk("B_ready_3rv", int'(bus.req_ready_o), 0);
      bus.cfg_r_valid_i = 1'b1;
      @(negedge clk);
      bus.cfg_r_valid_i = 1'b0;
      chk("B_en_last_rv",    int'(bus.hwpe_en_o),   1);
      chk("B_ready_last_rv", int'(bus.req_ready_o), 0);
      @(negedge clk);
      chk("B_en_gate", int'(bus.hwpe_en_o), 0);
      wait_ready(20);
      chk("B_sel_done", int'(bus.hwpe_sel_o), 0);
      chk("B_en_done",  int'(bus.hwpe_en_o),  1);

      // C: HWPE busy for 10 cycles during drain
      bus.hwpe_busy_i = 1'b1;
      request(1, 1);
      repeat (10) @(negedge clk);
      chk("C_en_busy",  int'(bus.hwpe_en_o),  1);
      chk("C_sel_busy", int'(bus.hwpe_sel_o), 0);
      bus.hwpe_busy_i = 1'b0;
      @(negedge clk);
      chk("C_en_gate", int'(bus.hwpe_en_o), 0);
      wait_ready(20);
      chk("C_sel_done", int'(bus.hwpe_sel_o), 1);

      // E: same sel, en 1->0 still traverses the full sequence
      request(1, 0);
      chk("E_ready_c1", int'(bus.req_ready_o), 0);
      wait_ready(20);
      chk("E_sel_done", int'(bus.hwpe_sel_o), 1);
      chk("E_en_done",  int'(bus.hwpe_en_o),  0);

      // D: out-of-range selector and a no-op request
      request(3, 1);
      chk("D_err_pulse", int'(bus.err_o),       1);
      chk("D_ready",     int'(bus.req_ready_o), 1);
      @(negedge clk);
      chk("D_err_clear", int'(bus.err_o),      0);
      chk("D_sel_keep",  int'(bus.hwpe_sel_o), 1);
      chk("D_en_keep",   int'(bus.hwpe_en_o),  0);
      request(1, 0);
      chk("D_noop_err",   int'(bus.err_o),       0);
      chk("D_noop_ready", int'(bus.req_ready_o), 1);

      // F: simultaneous grant and response keep the count at 1
      bus.cfg_req_i = 1'b1;
      bus.cfg_gnt_i = 1'b1;
      @(negedge clk);
      bus.cfg_r_valid_i = 1'b1;
      @(negedge clk);
      bus.cfg_req_i = 1'b0;
      bus.cfg_gnt_i = 1'b0;
      bus.cfg_r_valid_i = 1'b0;
      request(0, 1);
      repeat (4) @(negedge clk);
      chk("F_ready_cnt1", int'(bus.req_ready_o), 0);
      bus.cfg_r_valid_i = 1'b1;
      @(negedge clk);
      bus.cfg_r_valid_i = 1'b0;
      chk("F_err_last_rv", int'(bus.err_o), 0);
      wait_ready(20);
      chk("F_sel_done", int'(bus.hwpe_sel_o), 0);
      // Response with nothing outstanding
      bus.cfg_r_valid_i = 1'b1;
      @(negedge clk);
      bus.cfg_r_valid_i = 1'b0;
      chk("F_err_underflow", int'(bus.err_o), 1);
      @(negedge clk);
      chk("F_err_underflow_clr", int'(bus.err_o), 0);
      // Saturation: 16th grant overflows a 4-bit counter
      bus.cfg_req_i = 1'b1;
      bus.cfg_gnt_i = 1'b1;
      repeat (15) @(negedge clk);
      chk("F_err_at_max", int'(bus.err_o), 0);
      @(negedge clk);
      chk("F_err_saturate", int'(bus.err_o), 1);
      bus.cfg_req_i = 1'b0;
      bus.cfg_gnt_i = 1'b0;
      bus.cfg_r_valid_i = 1'b1;
      repeat (15) @(negedge clk);
      bus.cfg_r_valid_i = 1'b0;
      @(negedge clk);
      request(1, 1);
      wait_ready(20);
      chk("F_sel_final", int'(bus.hwpe_sel_o), 1);
      chk("F_en_final",  int'(bus.hwpe_en_o),  1);

      // G: reset asserted while gated aborts the sequence
      request(0, 1);
      @(negedge clk);
      chk("G_en_gate", int'(bus.hwpe_en_o), 0);
      #2 rst_n = 1'b0;
      #1;
      chk("G_rst_en",    int'(bus.hwpe_en_o),   0);
      chk("G_rst_sel",   int'(bus.hwpe_sel_o),  0);
      chk("G_rst_ready", int'(bus.req_ready_o), 1);
      chk("G_rst_block", int'(bus.cfg_block_o), 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      request(1, 1);
      chk("G_accept", int'(bus.req_ready_o), 0);
      wait_ready(20);
      chk("G_sel_done", int'(bus.hwpe_sel_o), 1);
      chk("G_en_done",  int'(bus.hwpe_en_o),  1);

      @(negedge clk);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
